// File: rtl/carbonio_pkg.sv
// Shared types and the round-robin search helper for the carbonio FIFO arbiter.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package carbonio_pkg;

    localparam int unsigned RR_MAX   = 8;
    localparam int unsigned RR_IDX_W = 3;
    localparam int unsigned RR_CNT_W = RR_IDX_W + 1;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Returns {found, idx}: first set bit of valid at or after ptr, wrapping modulo n.
    function automatic logic [RR_IDX_W:0] rr_pick(
        input logic [RR_MAX-1:0]   valid,
        input logic [RR_IDX_W-1:0] ptr,
        input logic [RR_CNT_W-1:0] n
    );
        logic                found;
        logic [RR_IDX_W-1:0] idx;
        logic [RR_CNT_W-1:0] off;
        logic [RR_CNT_W-1:0] k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            off = RR_CNT_W'(i);
            k   = {1'b0, ptr} + off;
            if (k >= n) begin
                k = k - n;
            end
            if (!found && (off < n) && valid[k[RR_IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = k[RR_IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/carbonio_fifo.sv
// Generic synchronous FIFO with registered occupancy count.
// Latency: a word pushed at edge N is at the head right after edge N (no bypass when empty).
// Backpressure: pushes while full and pops while empty are ignored.
module carbonio_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/carbonio_fifo_arb.sv
// Round-robin arbiter with burst lock sharing one tagged FIFO among NREQ requesters.
// Latency: grant is combinational; a pushed word appears on out_valid after the push edge.
// Backpressure: req_ready drops while the FIFO is full; out_ready stalls the head.
module carbonio_fifo_arb
    import carbonio_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SRC_W-1:0]      out_src,
    output logic [CNT_W-1:0]      fifo_count,
    output logic [SRC_W-1:0]      grant_id,
    output logic                  grant_active
);

    localparam int FW = SRC_W + WIDTH;

    arb_state_e          state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]    lock_id_q, lock_id_d;

    logic [RR_MAX-1:0]   valid_pad;
    logic [RR_IDX_W-1:0] ptr_pad;
    logic [RR_IDX_W:0]   pick;
    logic [SRC_W-1:0]    grant_idx;
    logic                grant_vld;

    logic                fifo_full;
    logic                fifo_empty;
    logic                push_vld;
    logic                pop_vld;
    logic [FW-1:0]       push_dat;
    logic [FW-1:0]       head_dat;

    always_comb begin
        valid_pad                = '0;
        valid_pad[NREQ-1:0]      = req_valid;
        ptr_pad                  = '0;
        ptr_pad[SRC_W-1:0]       = rr_ptr_q;
        pick                     = rr_pick(valid_pad, ptr_pad, RR_CNT_W'(NREQ));
        // A locked owner keeps the grant even while it has nothing to send.
        if (state_q == LOCKED) begin
            grant_vld = 1'b1;
            grant_idx = lock_id_q;
        end else begin
            grant_vld = pick[RR_IDX_W];
            grant_idx = pick[SRC_W-1:0];
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_vld && !fifo_full && req_valid[i] && (grant_idx == SRC_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
        push_vld = |req_ready;
        push_dat = {grant_idx, req_data[int'(grant_idx)*WIDTH +: WIDTH]};
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        if (push_vld) begin
            if (req_lock[grant_idx]) begin
                state_d   = LOCKED;
                lock_id_d = grant_idx;
            end else begin
                state_d  = ARB;
                rr_ptr_d = (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    carbonio_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .full     (fifo_full),
        .pop_vld  (pop_vld),
        .pop_dat  (head_dat),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign out_valid    = !fifo_empty;
    assign pop_vld      = out_valid && out_ready;
    assign out_src      = head_dat[FW-1 -: SRC_W];
    assign out_data     = head_dat[WIDTH-1:0];
    assign grant_id     = grant_idx;
    assign grant_active = grant_vld;

endmodule
